// File: rtl/cafe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cafe_pkg
// Description : Shared coin codes, coin values and credit width for the
//               coffee vending controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cafe_pkg;

    localparam int CREDIT_W = 5;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_20   = 2'b11;

    localparam logic [CREDIT_W-1:0] VAL_5  = 5'd5;
    localparam logic [CREDIT_W-1:0] VAL_10 = 5'd10;
    localparam logic [CREDIT_W-1:0] VAL_20 = 5'd20;

endpackage
`default_nettype wire

// File: rtl/cafe_coin_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cafe_coin_decoder
// Description : Combinational map from the 2-bit coin code to its value.
// Revision    : 1.0 - initial release
// ============================================================================
module cafe_coin_decoder
    import cafe_pkg::*;
(
    input  logic [1:0]          code,
    output logic [CREDIT_W-1:0] value
);

    always_comb begin
        value = '0;
        case (code)
            COIN_NONE: value = '0;
            COIN_5:    value = VAL_5;
            COIN_10:   value = VAL_10;
            COIN_20:   value = VAL_20;
            default:   value = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cafe_machine.sv
`default_nettype none
// ============================================================================
// Module      : cafe_machine
// Description : Coin-operated coffee controller; accumulates credit and
//               pulses a registered dispense strobe with the change amount.
// Revision    : 1.0 - initial release
// ============================================================================
module cafe_machine
    import cafe_pkg::*;
#(
    parameter int PRICE = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          in,
    output logic                out,
    output logic [CREDIT_W-1:0] change
);

    localparam logic [CREDIT_W-1:0] c_price = CREDIT_W'(PRICE);

    logic [CREDIT_W-1:0] r_credit;
    logic                r_out;
    logic [CREDIT_W-1:0] r_change;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_sum;
    logic                w_buy;

    cafe_coin_decoder u_decoder (
        .code  (in),
        .value (w_coin_val)
    );

    // Credit never exceeds PRICE-5, so the sum peaks at 30 and fits 5 bits.
    assign w_sum = r_credit + w_coin_val;
    assign w_buy = (w_sum >= c_price);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= '0;
            r_out    <= 1'b0;
            r_change <= '0;
        end else if (w_buy) begin
            r_credit <= '0;
            r_out    <= 1'b1;
            r_change <= w_sum - c_price;
        end else begin
            r_credit <= w_sum;
            r_out    <= 1'b0;
            r_change <= '0;
        end
    end

    assign out    = r_out;
    assign change = r_change;

endmodule
`default_nettype wire

// File: tb/tb_cafe_machine.sv
`default_nettype none
// ============================================================================
// Module      : tb_cafe_machine
// Description : Directed table-driven bench for cafe_machine at PRICE=15.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cafe_machine;

    logic       clk;
    logic       rst;
    logic [1:0] in;
    logic       out;
    logic [4:0] change;

    int n_checks;
    int n_fails;

    typedef struct {
        logic       rst;
        logic [1:0] in;
        logic       exp_out;
        logic [4:0] exp_change;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    cafe_machine #(.PRICE(15)) dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .out    (out),
        .change (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] c, input logic eo,
                        input logic [4:0] ec, input string name);
        rst = r;
        in  = c;
        @(posedge clk);
        #1;
        check({name, ".out"}, int'(out), int'(eo));
        check({name, ".change"}, int'(change), int'(ec));
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        in  = 2'b00;

        // reset with a coin present, then idle
        vecs[0]  = '{1'b1, 2'b11, 1'b0, 5'd0};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 5'd0};
        // two tens
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 5'd0};
        vecs[3]  = '{1'b0, 2'b10, 1'b1, 5'd5};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 5'd0};
        // five then twenty, twenty held
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 5'd0};
        vecs[6]  = '{1'b0, 2'b11, 1'b1, 5'd10};
        vecs[7]  = '{1'b0, 2'b11, 1'b1, 5'd5};
        // exact coins
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 5'd0};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 5'd0};
        vecs[10] = '{1'b0, 2'b01, 1'b1, 5'd0};
        vecs[11] = '{1'b0, 2'b10, 1'b0, 5'd0};
        vecs[12] = '{1'b0, 2'b01, 1'b1, 5'd0};
        // maximum change
        vecs[13] = '{1'b0, 2'b10, 1'b0, 5'd0};
        vecs[14] = '{1'b0, 2'b11, 1'b1, 5'd15};
        // idle cycles keep credit
        vecs[15] = '{1'b0, 2'b10, 1'b0, 5'd0};
        vecs[16] = '{1'b0, 2'b00, 1'b0, 5'd0};
        vecs[17] = '{1'b0, 2'b00, 1'b0, 5'd0};
        vecs[18] = '{1'b0, 2'b01, 1'b1, 5'd0};
        // mid-purchase reset discards credit and the coin
        vecs[19] = '{1'b0, 2'b10, 1'b0, 5'd0};
        vecs[20] = '{1'b1, 2'b10, 1'b0, 5'd0};
        vecs[21] = '{1'b0, 2'b01, 1'b0, 5'd0};
        vecs[22] = '{1'b0, 2'b10, 1'b1, 5'd0};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].in, vecs[i].exp_out, vecs[i].exp_change,
                 $sformatf("vec%0d", i));
        end

        // fives held constant: each cycle is a new coin, no dead cycle
        step(1'b0, 2'b01, 1'b0, 5'd0, "hold5_a");
        step(1'b0, 2'b01, 1'b0, 5'd0, "hold5_b");
        step(1'b0, 2'b01, 1'b1, 5'd0, "hold5_c");
        step(1'b0, 2'b01, 1'b0, 5'd0, "hold5_d");
        step(1'b0, 2'b01, 1'b0, 5'd0, "hold5_e");
        step(1'b0, 2'b01, 1'b1, 5'd0, "hold5_f");

        // outputs are registered: a mid-cycle coin change must not leak through
        in = 2'b11;
        #2;
        check("noleak.out", int'(out), 1);
        check("noleak.change", int'(change), 0);
        @(posedge clk);
        #1;
        check("twenty_from_zero.out", int'(out), 1);
        check("twenty_from_zero.change", int'(change), 5);

        // reset while a strobe is high clears it
        step(1'b1, 2'b11, 1'b0, 5'd0, "rst_clr");
        step(1'b0, 2'b00, 1'b0, 5'd0, "post_rst_idle");
        step(1'b0, 2'b10, 1'b0, 5'd0, "post_rst_ten");
        step(1'b0, 2'b10, 1'b1, 5'd5, "post_rst_buy");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
